hw2_pipe_sched: RTL and testbench
=================================

// Module: hw2_pipe_sched
// PURPOSE
//   Shares one hw2_pipe add/sub-multiply pipeline (d = (s ? a+b : a-b) * c) between two requesters.
//   Arbitrates one request per cycle and drives the pipe operand registers.
//   Tracks each in-flight operation with a requester tag.
//   Steers results into a per-requester response FIFO with valid/ready handshake. Sits between the client blocks and hw2_pipe.
// PARAMETERS
//   DATA_WIDTH   8   operand width of a, b, c; result width is 2*DATA_WIDTH
//   PIPE_LAT     2   cycles from pipe_* operand update to matching pipe_d
//   FIFO_DEPTH   4   entries per response FIFO (power of 2, >=2)
// PORTS
//   clk          in   1             single clock, rising edge
//   reset        in   1             asynchronous, active-low reset
//   reqN_valid   in   1             N=0,1: request present
//   reqN_ready   out  1             N=0,1: request accepted this cycle
//   reqN_a/b/c   in   DATA_WIDTH    N=0,1: operands
//   reqN_s       in   1             N=0,1: 1 = add, 0 = subtract
//   pipe_a/b/c   out  DATA_WIDTH    registered operands to hw2_pipe
//   pipe_s       out  1             registered op select to hw2_pipe
//   pipe_d       in   2*DATA_WIDTH  hw2_pipe result
//   rspN_valid   out  1             N=0,1: response FIFO non-empty
//   rspN_ready   in   1             N=0,1: consumer pops head this cycle
//   rspN_d       out  2*DATA_WIDTH  N=0,1: FIFO head
// BEHAVIOUR
//   Reset (reset=0, async): all outputs 0, FIFOs empty, tags invalid, in-flight counters 0, RR pointer=1.
//   - In-flight results at reset time are discarded. No response is produced for them after release.
//   Credit: requester N is eligible iff reqN_valid && (inflightN + countN < FIFO_DEPTH).
//   - A FIFO write therefore never sees a full FIFO; no result is ever dropped.
//   Grant: at most one grant per cycle.
//   - reqN_ready is combinational: eligible and selected.
//   - Transfer occurs on valid&&ready at edge E0.
//   Round-robin: if both eligible, grant the one NOT granted last; the pointer updates only on a grant.
//   - Requester 0 wins the first contention after reset.
//   Issue: at E0, pipe_a/b/c/s <= granted operands, tag shift register stage0 <= {1,N}.
//   - On cycles with no grant: pipe_* <= 0, stage0 <= invalid.
//   Tag shift register: depth PIPE_LAT+1.
//   - A valid tag leaving the last stage at edge E0+PIPE_LAT+1 writes pipe_d, unmodified, into FIFO N.
//   - At that same edge inflightN decrements.
//   - rspN_valid is high after E0+PIPE_LAT+1 (3 cycles for PIPE_LAT=2) if the FIFO was empty.
//   - Back-to-back grants give one result per cycle; results per requester stay in issue order.
//   Counters:
//   - inflightN: +1 on grant to N, -1 on tag retire for N; both in the same cycle => unchanged.
//   - countN: +1 on write, -1 on pop (rspN_valid && rspN_ready); both in the same cycle => unchanged.
//   - FIFO pointers wrap modulo FIFO_DEPTH.
//   Empty FIFO: rspN_valid=0, rspN_d holds the last head value. rspN_ready while empty is ignored.
//   Requester operands may change freely while reqN_ready=0. No combinational path from pipe_d to any output.
// CONFIGURATION
//   SCHED_FIXED_PRIO_EN defined: requester 0 always wins when both are eligible; no RR pointer.
//   - Requester 1 may starve under continuous req0 traffic.
//   SCHED_FIXED_PRIO_EN undefined (default): round-robin as above.
// TESTING
//   T1: req0 a=10,b=3,c=4,s=1, one request.
//       -> reqN_ready=1 same cycle; rsp0_valid 3 cycles after accept; rsp0_d=52. rsp1_valid stays 0.
//   T2: req1 a=20,b=7,c=3,s=0.
//       -> rsp1_d=39 after 3 cycles. No write to FIFO0.
//   T3: both valid every cycle for 8 cycles, rspN_ready=1.
//       -> grants alternate 0,1,0,1 (req0 first). Responses: 4 per FIFO, in order.
//       -> Repeat with SCHED_FIXED_PRIO_EN: all 8 grants to req0, req1_ready=0 throughout.
//   T4: rsp0_ready=0, req0 valid for 6 cycles.
//       -> exactly 4 accepts, then req0_ready=0. rsp0_valid=1 with 4 entries.
//       -> req1 still accepted and answered meanwhile.
//       -> Raise rsp0_ready: 1 pop per cycle and req0 resumes.
//   T5: 2 grants issued, then reset pulled low 1 cycle after issue.
//       -> rsp0/1_valid=0, pipe_*=0 immediately; no responses emerge after release.
//   T6: pop and retire-write to the same FIFO in the same cycle at count=2.
//       -> count stays 2, data order preserved.

Source files
------------

// File: rtl/hw2_pipe_sched_if.sv
// rtl/hw2_pipe_sched_if.sv - request, pipe and response signals of the hw2_pipe scheduler
//
// Purpose: groups the two request channels, the hw2_pipe operand/result
//   signals and the two response channels into one bundle.
// Modports:
//   slave  - the scheduler: takes requests, rspN_ready and pipe_d;
//            drives reqN_ready, pipe_a/b/c/s, rspN_valid and rspN_d.
//   master - the environment: client blocks plus the hw2_pipe itself.
interface hw2_pipe_sched_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      req0_valid;
  logic                      req0_ready;
  logic [DATA_WIDTH-1:0]     req0_a;
  logic [DATA_WIDTH-1:0]     req0_b;
  logic [DATA_WIDTH-1:0]     req0_c;
  logic                      req0_s;
  logic                      req1_valid;
  logic                      req1_ready;
  logic [DATA_WIDTH-1:0]     req1_a;
  logic [DATA_WIDTH-1:0]     req1_b;
  logic [DATA_WIDTH-1:0]     req1_c;
  logic                      req1_s;
  logic [DATA_WIDTH-1:0]     pipe_a;
  logic [DATA_WIDTH-1:0]     pipe_b;
  logic [DATA_WIDTH-1:0]     pipe_c;
  logic                      pipe_s;
  logic [2*DATA_WIDTH-1:0]   pipe_d;
  logic                      rsp0_valid;
  logic                      rsp0_ready;
  logic [2*DATA_WIDTH-1:0]   rsp0_d;
  logic                      rsp1_valid;
  logic                      rsp1_ready;
  logic [2*DATA_WIDTH-1:0]   rsp1_d;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_c, req0_s,
    input  req1_valid, req1_a, req1_b, req1_c, req1_s,
    output req0_ready, req1_ready,
    output pipe_a, pipe_b, pipe_c, pipe_s,
    input  pipe_d,
    output rsp0_valid, rsp0_d, rsp1_valid, rsp1_d,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_c, req0_s,
    output req1_valid, req1_a, req1_b, req1_c, req1_s,
    input  req0_ready, req1_ready,
    input  pipe_a, pipe_b, pipe_c, pipe_s,
    output pipe_d,
    input  rsp0_valid, rsp0_d, rsp1_valid, rsp1_d,
    output rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/hw2_pipe_sched.sv
// rtl/hw2_pipe_sched.sv - two-requester scheduler in front of the shared hw2_pipe
//
// Purpose: arbitrates one request per cycle onto hw2_pipe
//   (d = (s ? a+b : a-b) * c), tags every issued operation with its
//   requester and steers each result into that requester's response FIFO.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low reset
//   bus    - hw2_pipe_sched_if.slave: reqN_valid/ready/a/b/c/s,
//            pipe_a/b/c/s (registered operands), pipe_d (pipe result),
//            rspN_valid/ready/d (response FIFO heads)
// Configuration:
//   SCHED_FIXED_PRIO_EN - when defined, requester 0 always wins a contention
//                         (no round-robin pointer); default is round-robin.
module hw2_pipe_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int PIPE_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  hw2_pipe_sched_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 2 * DATA_WIDTH;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [1:0]            req_valid;
  logic [1:0]            rsp_ready;
  logic [1:0]            elig;
  logic [1:0]            grant;
  logic [1:0]            rsp_valid;
  logic [RW-1:0]         rsp_d [2];

  logic [DATA_WIDTH-1:0] pipe_a_q, pipe_b_q, pipe_c_q;
  logic                  pipe_s_q;

  // Tag shift register: one stage per cycle an operation spends between
  // operand issue and result capture.
  logic [PIPE_LAT:0]     tag_v;
  logic [PIPE_LAT:0]     tag_id;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  // ---------------------------------------------------------------- grant
`ifdef SCHED_FIXED_PRIO_EN
  assign grant = {elig[1] & ~elig[0], elig[0]};
`else
  logic rr_last;  // requester granted most recently

  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = rr_last ? 2'b01 : 2'b10;
    end
  end

  // Reset value 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last <= 1'b1;
    end else if (|grant) begin
      rr_last <= grant[1];
    end
  end
`endif

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  // ---------------------------------------------------------------- issue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_a_q <= '0;
      pipe_b_q <= '0;
      pipe_c_q <= '0;
      pipe_s_q <= 1'b0;
      tag_v    <= '0;
      tag_id   <= '0;
    end else begin
      tag_v  <= {tag_v[PIPE_LAT-1:0], |grant};
      tag_id <= {tag_id[PIPE_LAT-1:0], grant[1]};
      if (grant[0]) begin
        pipe_a_q <= bus.req0_a;
        pipe_b_q <= bus.req0_b;
        pipe_c_q <= bus.req0_c;
        pipe_s_q <= bus.req0_s;
      end else if (grant[1]) begin
        pipe_a_q <= bus.req1_a;
        pipe_b_q <= bus.req1_b;
        pipe_c_q <= bus.req1_c;
        pipe_s_q <= bus.req1_s;
      end else begin
        pipe_a_q <= '0;
        pipe_b_q <= '0;
        pipe_c_q <= '0;
        pipe_s_q <= 1'b0;
      end
    end
  end

  assign bus.pipe_a = pipe_a_q;
  assign bus.pipe_b = pipe_b_q;
  assign bus.pipe_c = pipe_c_q;
  assign bus.pipe_s = pipe_s_q;

  // ------------------------------------------------- per-requester state
  for (genvar n = 0; n < 2; n++) begin : g_rsp
    logic [CW-1:0] inflight;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [RW-1:0] mem [FIFO_DEPTH];
    logic [RW-1:0] last_d;
    logic          retire;
    logic          pop;

    // Credit covers both queued and in-flight results, so a retiring
    // result always finds room in the FIFO.
    assign elig[n] = req_valid[n] &&
                     (({1'b0, inflight} + {1'b0, count}) < DEPTH_C);
    assign retire  = tag_v[PIPE_LAT] && (tag_id[PIPE_LAT] == 1'(n));
    assign pop     = (count != '0) && rsp_ready[n];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        inflight <= '0;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        last_d   <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          mem[i] <= '0;
        end
      end else begin
        case ({grant[n], retire})
          2'b10:   inflight <= inflight + 1'b1;
          2'b01:   inflight <= inflight - 1'b1;
          default: inflight <= inflight;
        endcase
        case ({retire, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (retire) begin
          mem[wr_ptr] <= bus.pipe_d;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) begin
          last_d <= mem[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end

    // While empty, the head output keeps showing the last popped entry.
    assign rsp_valid[n] = (count != '0);
    assign rsp_d[n]     = (count != '0) ? mem[rd_ptr] : last_d;
  end

  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp0_d     = rsp_d[0];
  assign bus.rsp1_d     = rsp_d[1];

endmodule

// File: tb/tb_hw2_pipe_sched.sv
// tb/tb_hw2_pipe_sched.sv - self-checking bench for hw2_pipe_sched
module tb_hw2_pipe_sched;

  localparam int DW       = 8;
  localparam int RW       = 2 * DW;
  localparam int PIPE_LAT = 2;
  localparam int DEPTH    = 4;

  logic clk;
  logic rst_n;

  hw2_pipe_sched_if #(.DATA_WIDTH(DW)) bus ();

  hw2_pipe_sched #(
    .DATA_WIDTH(DW),
    .PIPE_LAT  (PIPE_LAT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] calc(logic [DW-1:0] a, logic [DW-1:0] b,
                                         logic [DW-1:0] c, logic s);
    logic [RW-1:0] t;
    t = s ? (RW'(a) + RW'(b)) : (RW'(a) - RW'(b));
    return t * RW'(c);
  endfunction

  // Stand-in for hw2_pipe: PIPE_LAT register stages after the operand regs.
  logic [RW-1:0] pstage [PIPE_LAT];
  initial for (int i = 0; i < PIPE_LAT; i++) pstage[i] = '0;
  always @(posedge clk) begin
    pstage[0] <= calc(bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_s);
    for (int i = 1; i < PIPE_LAT; i++) pstage[i] <= pstage[i-1];
  end
  assign bus.pipe_d = pstage[PIPE_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------- behavioural model
  // Every accepted request becomes a pending entry that turns visible
  // PIPE_LAT+2 cycles after the cycle it was accepted in.
  typedef struct {
    int            n;
    logic [RW-1:0] val;
    int            vis;
  } ent_t;

  ent_t          pend[$];
  int            outst [2];
  logic [RW-1:0] last_d [2];
  int            last_win;
  int            cyc;
  logic [DW-1:0] exp_a, exp_b, exp_c;
  logic          exp_s;
  int            grant_q[$];

  function automatic int head_idx(int n);
    foreach (pend[i]) if (pend[i].n == n) return i;
    return -1;
  endfunction

  task automatic model_reset();
    pend.delete();
    outst[0] = 0; outst[1] = 0;
    last_d[0] = '0; last_d[1] = '0;
    last_win = 1;
    cyc = 0;
    exp_a = '0; exp_b = '0; exp_c = '0; exp_s = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0]    vld, rdy, el;
    logic [DW-1:0] a [2];
    logic [DW-1:0] b [2];
    logic [DW-1:0] c [2];
    logic          s [2];
    logic          act_v [2];
    logic [RW-1:0] act_d [2];
    int            gnt, hi;
    logic          ev;
    logic [RW-1:0] ed;
    ent_t          e;
    vld = {bus.req1_valid, bus.req0_valid};
    rdy = {bus.rsp1_ready, bus.rsp0_ready};
    a[0] = bus.req0_a; b[0] = bus.req0_b; c[0] = bus.req0_c; s[0] = bus.req0_s;
    a[1] = bus.req1_a; b[1] = bus.req1_b; c[1] = bus.req1_c; s[1] = bus.req1_s;
    act_v[0] = bus.rsp0_valid; act_d[0] = bus.rsp0_d;
    act_v[1] = bus.rsp1_valid; act_d[1] = bus.rsp1_d;
    for (int n = 0; n < 2; n++) el[n] = vld[n] && (outst[n] < DEPTH);
    gnt = -1;
`ifdef SCHED_FIXED_PRIO_EN
    if (el[0]) gnt = 0;
    else if (el[1]) gnt = 1;
`else
    if (el[0] && el[1]) gnt = 1 - last_win;
    else if (el[0]) gnt = 0;
    else if (el[1]) gnt = 1;
`endif
    chk("req0_ready", 32'(bus.req0_ready), 32'(gnt == 0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(gnt == 1));
    chk("pipe_a", 32'(bus.pipe_a), 32'(exp_a));
    chk("pipe_b", 32'(bus.pipe_b), 32'(exp_b));
    chk("pipe_c", 32'(bus.pipe_c), 32'(exp_c));
    chk("pipe_s", 32'(bus.pipe_s), 32'(exp_s));
    for (int n = 0; n < 2; n++) begin
      hi = head_idx(n);
      ev = (hi >= 0) && (pend[hi].vis <= cyc);
      ed = ev ? pend[hi].val : last_d[n];
      chk($sformatf("rsp%0d_valid", n), 32'(act_v[n]), 32'(ev));
      chk($sformatf("rsp%0d_d", n), 32'(act_d[n]), 32'(ed));
      if (ev && rdy[n]) begin
        last_d[n] = pend[hi].val;
        pend.delete(hi);
        outst[n]--;
      end
    end
    if (gnt >= 0) begin
      e.n   = gnt;
      e.val = calc(a[gnt], b[gnt], c[gnt], s[gnt]);
      e.vis = cyc + PIPE_LAT + 2;
      pend.push_back(e);
      outst[gnt]++;
      last_win = gnt;
      exp_a = a[gnt]; exp_b = b[gnt]; exp_c = c[gnt]; exp_s = s[gnt];
      grant_q.push_back(gnt);
    end else begin
      exp_a = '0; exp_b = '0; exp_c = '0; exp_s = 1'b0;
    end
    cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int n, logic v, logic [DW-1:0] a, logic [DW-1:0] b,
                       logic [DW-1:0] c, logic s);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_c = c; bus.req0_s = s;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_c = c; bus.req1_s = s;
    end
  endtask

  task automatic drive_rand(int n, logic v);
    drive(n, v, DW'($urandom), DW'($urandom), DW'($urandom), 1'($urandom));
  endtask

  task automatic wait_idle();
    int k;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    k = 0;
    while ((outst[0] != 0 || outst[1] != 0) && k < 64) begin
      tick();
      k++;
    end
    checks++;
    if (k >= 64) begin
      errors++;
      $display("FAIL wait_idle: got outstanding %0d/%0d expected 0/0", outst[0], outst[1]);
    end
    tick();
  endtask

  function automatic int count_grants(int n);
    int k;
    k = 0;
    foreach (grant_q[i]) if (grant_q[i] == n) k++;
    return k;
  endfunction

  initial begin
    int seen;
    rst_n = 1'b0;
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    tick(); tick();
    chk("reset_rsp0_valid", 32'(bus.rsp0_valid), 0);
    chk("reset_rsp1_valid", 32'(bus.rsp1_valid), 0);
    chk("reset_pipe_a", 32'(bus.pipe_a), 0);
    chk("reset_rsp0_d", 32'(bus.rsp0_d), 0);
    rst_n = 1'b1;
    tick();

    // T1: single add request from requester 0
    bus.rsp0_ready = 1'b0;
    drive(0, 1'b1, 8'd10, 8'd3, 8'd4, 1'b1);
    #1 chk("t1_ready", 32'(bus.req0_ready), 1);
    tick();
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    tick(); tick();
    chk("t1_valid_early", 32'(bus.rsp0_valid), 0);
    tick();
    chk("t1_valid", 32'(bus.rsp0_valid), 1);
    chk("t1_d", 32'(bus.rsp0_d), 52);
    chk("t1_rsp1_valid", 32'(bus.rsp1_valid), 0);
    wait_idle();

    // T2: single subtract request from requester 1
    bus.rsp1_ready = 1'b0;
    drive(1, 1'b1, 8'd20, 8'd7, 8'd3, 1'b0);
    #1 chk("t2_ready", 32'(bus.req1_ready), 1);
    tick();
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    tick(); tick(); tick();
    chk("t2_valid", 32'(bus.rsp1_valid), 1);
    chk("t2_d", 32'(bus.rsp1_d), 39);
    chk("t2_rsp0_valid", 32'(bus.rsp0_valid), 0);
    wait_idle();

    // T3: continuous contention
    grant_q.delete();
    for (int i = 0; i < 8; i++) begin
      drive_rand(0, 1'b1);
      drive_rand(1, 1'b1);
      tick();
    end
    chk("t3_first_grant", 32'(grant_q.size() > 0 ? grant_q[0] : -1), 0);
`ifndef SCHED_FIXED_PRIO_EN
    chk("t3_grants0", 32'(count_grants(0)), 4);
    chk("t3_grants1", 32'(count_grants(1)), 4);
    for (int i = 1; i < 8; i++)
      if (i < grant_q.size())
        chk("t3_alternate", 32'(grant_q[i]), 32'(i % 2));
`endif
    wait_idle();

    // T4: requester 0 stalls on full credit while requester 1 proceeds
    bus.rsp0_ready = 1'b0;
    grant_q.delete();
    for (int i = 0; i < 6; i++) begin
      drive_rand(0, 1'b1);
      tick();
    end
    chk("t4_accepts", 32'(count_grants(0)), 4);
    chk("t4_ready_low", 32'(bus.req0_ready), 0);
    grant_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive_rand(0, 1'b1);
      drive_rand(1, 1'b1);
      tick();
    end
    chk("t4_req1_accepts", 32'(count_grants(1)), 4);
    chk("t4_req0_blocked", 32'(count_grants(0)), 0);
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_rsp0_full", 32'(bus.rsp0_valid), 1);
    bus.rsp0_ready = 1'b1;
    grant_q.delete();
    for (int i = 0; i < 8; i++) begin
      drive_rand(0, 1'b1);
      tick();
    end
    chk("t4_resumed", 32'(count_grants(0) > 0), 1);
    wait_idle();

    // T6: pop and retire-write to FIFO0 in the same cycle at two entries
    bus.rsp0_ready = 1'b0;
    drive(0, 1'b1, 8'd1, 8'd1, 8'd1, 1'b1);
    tick();
    drive(0, 1'b1, 8'd5, 8'd2, 8'd6, 1'b0);
    tick();
    drive(0, 1'b1, 8'd7, 8'd1, 8'd2, 1'b1);
    tick();
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    tick(); tick();
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    chk("t6_valid", 32'(bus.rsp0_valid), 1);
    chk("t6_head2", 32'(bus.rsp0_d), 18);
    bus.rsp0_ready = 1'b1;
    tick();
    chk("t6_head3", 32'(bus.rsp0_d), 16);
    tick();
    chk("t6_empty", 32'(bus.rsp0_valid), 0);
    chk("t6_hold", 32'(bus.rsp0_d), 16);
    wait_idle();

    // T5: reset with two operations in flight
    drive(0, 1'b1, 8'd9, 8'd4, 8'd2, 1'b1);
    tick();
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    drive(1, 1'b1, 8'd11, 8'd5, 8'd3, 1'b1);
    tick();
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rsp0_valid", 32'(bus.rsp0_valid), 0);
    chk("t5_rsp1_valid", 32'(bus.rsp1_valid), 0);
    chk("t5_pipe_a", 32'(bus.pipe_a), 0);
    chk("t5_pipe_s", 32'(bus.pipe_s), 0);
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rsp0_valid || bus.rsp1_valid) seen++;
    end
    chk("t5_no_stale", 32'(seen), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive_rand(0, 1'($urandom_range(0, 9) < 7));
      drive_rand(1, 1'($urandom_range(0, 9) < 6));
      bus.rsp0_ready = 1'($urandom_range(0, 9) < 7);
      bus.rsp1_ready = 1'($urandom_range(0, 9) < 5);
      tick();
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
